// File: rtl/bike_keygen_pkg.sv
// bike_keygen_pkg: shared constants for the BIKE key-generation blocks.
// Holds the sparse generator FSM encoding, default ring/weight/width
// constants and a saturating counter helper.
package bike_keygen_pkg;

    localparam int R_DEF        = 10163;
    localparam int W_DEF        = 71;
    localparam int H_DAT_W_DEF  = 14;
    localparam int H_ADDR_W_DEF = 7;
    localparam int RND_W_DEF    = 32;

    typedef logic [2:0] sg_state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    localparam logic [15:0] REJ_MAX = 16'hFFFF;

    // Increment a 16-bit statistic, holding at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == REJ_MAX) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/sparse_gen_if.sv
// sparse_gen_if: random-word handshake plus sparse RAM port of sparse_gen.
// master = the generator, slave = random source / RAM side.
interface sparse_gen_if #(
    parameter int RND_W    = 32,
    parameter int H_ADDR_W = 7,
    parameter int H_DAT_W  = 14
);
    logic                rnd_valid;
    logic                rnd_ready;
    logic [RND_W-1:0]    rnd_data;
    logic [H_ADDR_W-1:0] h_spa_addra;
    logic                h_spa_wea;
    logic [H_DAT_W-1:0]  h_spa_douta;
    logic [H_DAT_W-1:0]  h_spa_dina;

    modport master (
        input  rnd_valid, rnd_data, h_spa_dina,
        output rnd_ready, h_spa_addra, h_spa_wea, h_spa_douta
    );

    modport slave (
        output rnd_valid, rnd_data, h_spa_dina,
        input  rnd_ready, h_spa_addra, h_spa_wea, h_spa_douta
    );
endinterface

// File: rtl/sparse_gen_dup_scan.sv
// sparse_dup_scan: owns the sparse RAM address register. In scan mode it
// walks addresses 0..last, one per cycle, and compares each read word with
// the candidate one cycle later (RAM read latency), flagging hit or miss.
// In load mode it simply presents the write address for the parent.
module sparse_dup_scan #(
    parameter int H_ADDR_W = 7,
    parameter int H_DAT_W  = 14
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                start_i,
    input  logic                load_i,
    input  logic [H_ADDR_W-1:0] load_addr_i,
    input  logic [H_ADDR_W-1:0] last_addr_i,
    input  logic [H_DAT_W-1:0]  cand_i,
    input  logic [H_DAT_W-1:0]  dina_i,
    output logic [H_ADDR_W-1:0] addr_o,
    output logic                hit_o,
    output logic                miss_o
);
    logic [H_ADDR_W-1:0] addr_q;
    logic                issue_q;     // addr_q is a live read this cycle
    logic                cmp_q;       // dina_i holds data for a scanned address
    logic                cmp_last_q;  // that address was the last one
    logic                eq_s;

    assign eq_s   = (dina_i == cand_i);
    assign hit_o  = cmp_q & eq_s;
    assign miss_o = cmp_q & cmp_last_q & ~eq_s;
    assign addr_o = addr_q;

    // Address sequencer and compare pipeline; a hit or final miss ends the scan.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            addr_q     <= '0;
            issue_q    <= 1'b0;
            cmp_q      <= 1'b0;
            cmp_last_q <= 1'b0;
        end else if (load_i) begin
            addr_q     <= load_addr_i;
            issue_q    <= 1'b0;
            cmp_q      <= 1'b0;
            cmp_last_q <= 1'b0;
        end else if (start_i) begin
            addr_q     <= '0;
            issue_q    <= 1'b1;
            cmp_q      <= 1'b0;
            cmp_last_q <= 1'b0;
        end else if (hit_o || miss_o) begin
            issue_q    <= 1'b0;
            cmp_q      <= 1'b0;
            cmp_last_q <= 1'b0;
        end else if (issue_q) begin
            cmp_q      <= 1'b1;
            cmp_last_q <= (addr_q == last_addr_i);
            if (addr_q == last_addr_i) begin
                issue_q <= 1'b0;
            end else begin
                addr_q <= addr_q + H_ADDR_W'(1);
            end
        end else begin
            cmp_q      <= 1'b0;
            cmp_last_q <= 1'b0;
        end
    end

endmodule

// File: rtl/sparse_gen.sv
// sparse_gen: draws W distinct positions in 0..r-1 from a random word
// stream and writes them to a sparse RAM at addresses 0..W-1. Out-of-range
// words and duplicates are discarded, since the downstream dense expansion
// XORs each position in and a duplicate would cancel a bit.
// Optional feature: define SPARSE_GEN_STAT_EN to add the reject_cnt output.
module sparse_gen
    import bike_keygen_pkg::*;
#(
    parameter int r        = R_DEF,
    parameter int W        = W_DEF,
    parameter int H_ADDR_W = H_ADDR_W_DEF,
    parameter int H_DAT_W  = H_DAT_W_DEF,
    parameter int RND_W    = RND_W_DEF
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    output logic          done,
    sparse_gen_if.master  bus
`ifdef SPARSE_GEN_STAT_EN
    ,
    output logic [15:0]   reject_cnt
`endif
);
    localparam int CNT_W = $clog2(W + 1);
    localparam logic [H_DAT_W:0] R_LIM = (H_DAT_W + 1)'(r);
    localparam logic [CNT_W-1:0] W_LIM = CNT_W'(W);

    sg_state_t            state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d, count_inc_s;
    logic [H_DAT_W-1:0]   cand_q, cand_d, rnd_cand_s;
    logic                 rnd_ready_q, wea_q, done_q;
    logic [H_DAT_W-1:0]   douta_q;
    logic                 hs_s, in_range_s;
    logic                 scan_start_s, scan_load_s, hit_s, miss_s;
    logic [H_ADDR_W-1:0]  last_addr_s, scan_addr_s;

    assign rnd_cand_s  = bus.rnd_data[H_DAT_W-1:0];
    assign hs_s        = bus.rnd_valid & rnd_ready_q;
    assign in_range_s  = ({1'b0, rnd_cand_s} < R_LIM);
    assign count_inc_s = count_q + CNT_W'(1);
    assign last_addr_s = H_ADDR_W'(count_q - CNT_W'(1));
    assign scan_load_s = (state_d == ST_WRITE);

    // Next-state, entry count and candidate selection.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        cand_d       = cand_q;
        scan_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    count_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (hs_s) begin
                    cand_d = rnd_cand_s;
                    if (!in_range_s) begin
                        state_d = ST_FETCH;
                    end else if (count_q == '0) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d      = ST_CHECK;
                        scan_start_s = 1'b1;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_CHECK: begin
                if (hit_s) begin
                    state_d = ST_FETCH;
                end else if (miss_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_WRITE: begin
                count_d = count_inc_s;
                if (count_inc_s == W_LIM) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            cand_q      <= '0;
            rnd_ready_q <= 1'b0;
            wea_q       <= 1'b0;
            douta_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            cand_q      <= cand_d;
            rnd_ready_q <= (state_d == ST_FETCH);
            wea_q       <= (state_d == ST_WRITE);
            douta_q     <= (state_d == ST_WRITE) ? cand_d : '0;
            done_q      <= (state_d == ST_FIN);
        end
    end

    sparse_dup_scan #(
        .H_ADDR_W (H_ADDR_W),
        .H_DAT_W  (H_DAT_W)
    ) u_scan (
        .clk         (clk),
        .rst_b       (rst_b),
        .start_i     (scan_start_s),
        .load_i      (scan_load_s),
        .load_addr_i (H_ADDR_W'(count_q)),
        .last_addr_i (last_addr_s),
        .cand_i      (cand_q),
        .dina_i      (bus.h_spa_dina),
        .addr_o      (scan_addr_s),
        .hit_o       (hit_s),
        .miss_o      (miss_s)
    );

    assign bus.rnd_ready   = rnd_ready_q;
    assign bus.h_spa_addra = scan_addr_s;
    assign bus.h_spa_wea   = wea_q;
    assign bus.h_spa_douta = douta_q;
    assign done            = done_q;

`ifdef SPARSE_GEN_STAT_EN
    logic [15:0] rej_q;
    logic        range_rej_s;

    assign range_rej_s = (state_q == ST_FETCH) & hs_s & ~in_range_s;

    // Count range and duplicate rejects since the last start, saturating.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rej_q <= 16'd0;
        end else if ((state_q == ST_IDLE) && start) begin
            rej_q <= 16'd0;
        end else if (range_rej_s || hit_s) begin
            rej_q <= sat_inc16(rej_q);
        end else begin
            rej_q <= rej_q;
        end
    end

    assign reject_cnt = rej_q;
`endif

endmodule
